// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: 2-bit counter encodings,
// the index-width helper and the sequential PC increment.
package branch_predictor_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic int unsigned idx_width(input int unsigned entries);
    return $clog2(entries);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  input  logic       force_strong,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (force_strong) begin
      nxt = CNT_ST;
    end else if (taken) begin
      if (cur != CNT_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CNT_SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + tagged BTB predictor with EX-stage redirect/flush.
// Optional performance counters are enabled with `define BRANCH_PERF_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_branch,
  input  logic        ex_uncond,
  input  logic        ex_stall,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0] perf_total,
  output logic [31:0] perf_taken,
  output logic [31:0] perf_mispredict
`endif
);

  localparam int unsigned IDX_W = idx_width(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;

  logic [1:0]       cnt   [ENTRIES];
  logic [TAG_W-1:0] tag   [ENTRIES];
  logic [31:0]      tgt   [ENTRIES];
  logic [ENTRIES-1:0] valid;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             hit;
  logic             resolve;
  logic             mispredict;
  logic [1:0]       cnt_nxt;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign if_tag = if_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign ex_tag = ex_pc[TAG_LO+TAG_W-1:TAG_LO];

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign hit         = valid[if_idx] && (tag[if_idx] == if_tag);
  assign pred_taken  = hit && cnt[if_idx][1];
  assign pred_target = pred_taken ? tgt[if_idx] : (if_pc + PC_INC);

  assign resolve    = ex_branch && !ex_stall && !reset;
  assign mispredict = resolve &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));

  assign redirect    = mispredict;
  assign flush       = mispredict;
  assign redirect_pc = mispredict ? (ex_taken ? ex_target : (ex_pc + PC_INC)) : '0;

  sat_counter2 u_sat (
    .cur          (cnt[ex_idx]),
    .taken        (ex_taken),
    .force_strong (ex_uncond),
    .nxt          (cnt_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '{default: CNT_WNT};
      tag   <= '{default: '0};
      tgt   <= '{default: '0};
      valid <= '0;
    end else if (resolve) begin
      cnt[ex_idx] <= cnt_nxt;
      if (ex_taken) begin
        valid[ex_idx] <= 1'b1;
        tag[ex_idx]   <= ex_tag;
        tgt[ex_idx]   <= ex_target;
      end
    end
  end

`ifdef BRANCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_total      <= '0;
      perf_taken      <= '0;
      perf_mispredict <= '0;
    end else begin
      if (resolve)             perf_total      <= perf_total + 32'd1;
      if (resolve && ex_taken) perf_taken      <= perf_taken + 32'd1;
      if (mispredict)          perf_mispredict <= perf_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized checking of branch_predictor against a
// table-of-integers reference model.
module tb_branch_predictor;

  localparam int ENT = 16;
  localparam int IW  = 4;
  localparam int TW  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_branch, ex_uncond, ex_stall, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        redirect, flush;
  logic [31:0] redirect_pc;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_total, perf_taken, perf_mispredict;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENT), .TAG_W(TW)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_branch      (ex_branch),
    .ex_uncond      (ex_uncond),
    .ex_stall       (ex_stall),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
`ifdef BRANCH_PERF_EN
    ,
    .perf_total      (perf_total),
    .perf_taken      (perf_taken),
    .perf_mispredict (perf_mispredict)
`endif
  );

  // Reference model: plain integer tables indexed by word address modulo ENT.
  int          m_cnt [ENT];
  bit          m_val [ENT];
  int          m_tag [ENT];
  logic [31:0] m_tgt [ENT];
  logic [31:0] m_total, m_tkn, m_mis;

  int n_assert = 0;
  int n_fail   = 0;

  logic        o_pt, o_rd;
  logic [31:0] o_ptg, o_rpc;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int mtagof(input logic [31:0] pc);
    return int'((pc >> (2 + IW)) % (1 << TW));
  endfunction

  function automatic logic m_pt(input logic [31:0] pc);
    int i = midx(pc);
    return m_val[i] && (m_tag[i] == mtagof(pc)) && (m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_ptg(input logic [31:0] pc);
    return m_pt(pc) ? m_tgt[midx(pc)] : pc + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_cnt[i] = 1;
      m_val[i] = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = '0;
    end
    m_total = '0;
    m_tkn   = '0;
    m_mis   = '0;
  endtask

  // One clock cycle: drive, check combinational outputs against the model, then clock the model.
  task automatic cyc(input logic rst, input logic [31:0] ipc,
                     input logic br, input logic unc, input logic stl,
                     input logic [31:0] epc, input logic tk, input logic [31:0] etgt,
                     input logic ptk, input logic [31:0] ptgt);
    logic ev, mp;
    int   i;
    @(negedge clk);
    reset = rst; if_pc = ipc; ex_branch = br; ex_uncond = unc; ex_stall = stl;
    ex_pc = epc; ex_taken = tk; ex_target = etgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    #1;
    ev = br && !stl && !rst;
    mp = ev && ((tk != ptk) || (tk && (etgt != ptgt)));
    o_pt = pred_taken; o_ptg = pred_target; o_rd = redirect; o_rpc = redirect_pc;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pt(ipc)});
    chk("pred_target", pred_target, m_ptg(ipc));
    chk("redirect", {31'd0, redirect}, {31'd0, mp});
    chk("flush", {31'd0, flush}, {31'd0, mp});
    chk("redirect_pc", redirect_pc, mp ? (tk ? etgt : epc + 32'd4) : 32'd0);
`ifdef BRANCH_PERF_EN
    chk("perf_total", perf_total, m_total);
    chk("perf_taken", perf_taken, m_tkn);
    chk("perf_mispredict", perf_mispredict, m_mis);
`endif
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (ev) begin
      i = midx(epc);
      if (unc)     m_cnt[i] = 3;
      else if (tk) m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
      else         m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      if (tk) begin
        m_val[i] = 1'b1;
        m_tag[i] = mtagof(epc);
        m_tgt[i] = etgt;
      end
      m_total++;
      if (tk) m_tkn++;
      if (mp) m_mis++;
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(1'b0, ipc, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    int pulses;
    logic [31:0] ipc, epc, etgt, ptgt;
    logic br, unc, stl, tk, ptk, rst;
`ifdef BRANCH_PERF_EN
    logic [31:0] tot_before;
`endif

    m_reset();
    cyc(1'b1, 32'h1010, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    cyc(1'b1, 32'h1010, 1'b1, 1'b0, 1'b0, 32'h1010, 1'b1, 32'h1018, 1'b0, 32'd0);
    chk("rst_redirect", {31'd0, o_rd}, 32'd0);
    chk("rst_redirect_pc", o_rpc, 32'd0);

    // 1: cold lookup
    idle(32'h1010);
    chk("tp1_pt", {31'd0, o_pt}, 32'd0);
    chk("tp1_ptg", o_ptg, 32'h1014);

    // 2: first taken resolve mispredicts, then predicts taken
    cyc(1'b0, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h1010, 1'b1, 32'h1018, 1'b0, 32'h1014);
    chk("tp2_redirect", {31'd0, o_rd}, 32'd1);
    chk("tp2_rpc", o_rpc, 32'h1018);
    idle(32'h1010);
    chk("tp2_pt", {31'd0, o_pt}, 32'd1);
    chk("tp2_ptg", o_ptg, 32'h1018);
    chk("tp2_noredirect", {31'd0, o_rd}, 32'd0);

    // 3: correct prediction, then two not-taken
    cyc(1'b0, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h1010, 1'b1, 32'h1018, 1'b1, 32'h1018);
    chk("tp3_correct", {31'd0, o_rd}, 32'd0);
    cyc(1'b0, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h1010, 1'b0, 32'h1018, 1'b1, 32'h1018);
    cyc(1'b0, 32'h2000, 1'b1, 1'b0, 1'b0, 32'h1010, 1'b0, 32'h1018, 1'b1, 32'h1018);
    chk("tp3_rpc2", o_rpc, 32'h1014);
    idle(32'h1010);
    chk("tp3_pt", {31'd0, o_pt}, 32'd0);

    // 4: stalled branch resolves once
`ifdef BRANCH_PERF_EN
    tot_before = m_total;
`endif
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 32'h2000, 1'b1, 1'b0, (k < 3), 32'h101C, 1'b0, 32'h1030, 1'b1, 32'h1030);
      if (o_rd) pulses++;
    end
    chk("tp4_pulses", pulses, 32'd1);
    chk("tp4_last", {31'd0, o_rd}, 32'd1);
    chk("tp4_rpc", o_rpc, 32'h1020);
`ifdef BRANCH_PERF_EN
    idle(32'h2000);
    chk("tp4_perf_total", m_total - tot_before, 32'd1);
`endif

    // 5: same-index update and lookup, then alias with different tag
    cyc(1'b0, 32'h1010, 1'b1, 1'b0, 1'b0, 32'h1010, 1'b1, 32'h1018, 1'b0, 32'h1014);
    chk("tp5_old", {31'd0, o_pt}, 32'd0);
    idle(32'h1010);
    chk("tp5_new", {31'd0, o_pt}, 32'd1);
    idle(32'h1050);
    chk("tp5_alias", {31'd0, o_pt}, 32'd0);
    chk("tp5_alias_tgt", o_ptg, 32'h1054);

    // 6: JAL trains strongly, reset discards it
    cyc(1'b0, 32'h2000, 1'b1, 1'b1, 1'b0, 32'h1054, 1'b1, 32'h1054, 1'b0, 32'h1058);
    idle(32'h1054);
    chk("tp6_jal", {31'd0, o_pt}, 32'd1);
    cyc(1'b1, 32'h1054, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(32'h1054);
    chk("tp6_after_rst", {31'd0, o_pt}, 32'd0);
    chk("tp6_after_rst_tgt", o_ptg, 32'h1058);

    // Randomized traffic over a small PC window so indices alias and tags collide
    for (int n = 0; n < 400; n++) begin
      ipc  = 32'h1000 + 32'(4 * $urandom_range(0, 63));
      epc  = 32'h1000 + 32'(4 * $urandom_range(0, 63));
      etgt = 32'h1000 + 32'(4 * $urandom_range(0, 63));
      br   = ($urandom_range(0, 3) != 0);
      unc  = ($urandom_range(0, 7) == 0);
      stl  = ($urandom_range(0, 4) == 0);
      tk   = unc ? 1'b1 : 1'(($urandom_range(0, 1)));
      rst  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) != 0) begin
        ptk  = m_pt(epc);
        ptgt = m_ptg(epc);
      end else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = ($urandom_range(0, 1) != 0) ? etgt : epc + 32'd4;
      end
      cyc(rst, ipc, br, unc, stl, epc, tk, etgt, ptk, ptgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
